// File: rtl/led_frame_decoder.sv
// led_frame_decoder: parses SYNC/COUNT/pixels/CHECK byte frames from the UART receiver
// Latency: write strobe, commit and error pulses appear one cycle after the deciding byte edge
// Backpressure: none; one byte accepted every clock, nothing is ever dropped
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   rx_data/_ready      byte and its single-cycle strobe from the UART receiver
//   wr_en/addr/data     one-cycle shadow-memory write of a 24-bit pixel {b0,b1,b2}
//   frame_commit/error  one-cycle end-of-frame pulses (checksum good / frame aborted)
//   busy                high while a frame is being parsed
module led_frame_decoder #(
  parameter int         MAX_LEDS       = 64,
  parameter int         ADDR_WIDTH     = 6,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1200
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [23:0]           wr_data,
  output logic                  frame_commit,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int GW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_PIXEL,
    S_CHECK
  } state_t;

  state_t                r_state;
  logic [7:0]            r_xor;
  logic [7:0]            r_count;
  logic [7:0]            r_led_idx;
  logic [1:0]            r_byte_idx;
  logic [7:0]            r_b0;
  logic [7:0]            r_b1;
  logic [GW-1:0]         r_gap;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [23:0]           r_wr_data;
  logic                  r_commit;
  logic                  r_error;
  logic                  r_busy;

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign frame_commit = r_commit;
  assign frame_error  = r_error;
  assign busy         = r_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_xor      <= '0;
      r_count    <= '0;
      r_led_idx  <= '0;
      r_byte_idx <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_gap      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_commit   <= 1'b0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_commit <= 1'b0;
      r_error  <= 1'b0;

      // Idle-gap counter: only meaningful inside a frame, saturates at the trip value.
      if (rx_data_ready || r_state == S_IDLE) begin
        r_gap <= '0;
      end else if (r_gap != GAP_MAX) begin
        r_gap <= r_gap + GW'(1);
      end

      if (r_state == S_IDLE) begin
        r_xor      <= '0;
        r_led_idx  <= '0;
        r_byte_idx <= '0;
        if (rx_data_ready && rx_data == SYNC_BYTE) begin
          r_state <= S_COUNT;
          r_busy  <= 1'b1;
        end
      end else if (rx_data_ready) begin
        // A byte always beats a timeout firing in the same cycle.
        case (r_state)
          S_COUNT: begin
            r_count <= rx_data;
            r_xor   <= rx_data;
            if (rx_data == 8'd0) begin
              r_state <= S_CHECK;
            end else if (rx_data > 8'(MAX_LEDS)) begin
              r_error <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_PIXEL;
            end
          end
          S_PIXEL: begin
            r_xor <= r_xor ^ rx_data;
            case (r_byte_idx)
              2'd0: begin
                r_b0       <= rx_data;
                r_byte_idx <= 2'd1;
              end
              2'd1: begin
                r_b1       <= rx_data;
                r_byte_idx <= 2'd2;
              end
              default: begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= ADDR_WIDTH'(r_led_idx);
                r_wr_data  <= {r_b0, r_b1, rx_data};
                r_byte_idx <= 2'd0;
                r_led_idx  <= r_led_idx + 8'd1;
                if (r_led_idx == r_count - 8'd1) begin
                  r_state <= S_CHECK;
                end
              end
            endcase
          end
          default: begin
            // S_CHECK: the deciding byte
            if (rx_data == r_xor) begin
              r_commit <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (r_gap == GAP_MAX) begin
        r_error <= 1'b1;
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

endmodule
